// File: rtl/lc3b_types.sv
// Shared LC-3b types for the out-of-order core, plus the reorder buffer
// entry layout used by reorder_buffer.
package lc3b_types;

  typedef logic [15:0] lc3b_word;
  typedef logic [3:0]  lc3b_opcode;
  typedef logic [2:0]  lc3b_reg;
  typedef logic [2:0]  lc3b_rob_addr;

  // One reorder buffer slot. busy = allocated and not yet committed,
  // done = result has arrived from the CDB.
  typedef struct packed {
    logic       busy;
    logic       done;
    lc3b_opcode opcode;
    lc3b_reg    dest;
    lc3b_word   value;
    logic       predict;
    lc3b_word   pc;
  } rob_entry;

endpackage

// File: rtl/reorder_buffer_rob_ptr.sv
// Modulo-2**width pointer used for the reorder buffer head and tail.
// clr has priority over inc; wrap-around is the natural binary rollover.
module rob_ptr #(
  parameter int width = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [width-1:0] value
);

  // Pointer register: clear, else advance by one.
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)      value <= '0;
    else if (clr) value <= '0;
    else if (inc) value <= value + width'(1);
  end

endmodule

// File: rtl/reorder_buffer.sv
// Circular reorder buffer feeding in-order commit.
// Dispatch allocates at the tail, the CDB marks entries done, the commit
// controller pops the head with RE, and flush empties everything.
// Build option: define ROB_BYPASS_EN to forward a same-cycle CDB write
// combinationally to the head outputs and the two operand read ports.
module reorder_buffer
  import lc3b_types::*;
#(
  parameter int data_width = 16,
  parameter int depth      = 8    // must equal 2**$bits(lc3b_rob_addr)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  WE,
  input  lc3b_opcode            inst_opcode,
  input  lc3b_reg               inst_dest,
  input  logic [15:0]           inst_pc,
  input  logic                  inst_predict,
  output lc3b_rob_addr          alloc_addr,
  output logic                  full,
  output logic                  empty,
  input  logic                  cdb_valid,
  input  lc3b_rob_addr          cdb_tag,
  input  logic [data_width-1:0] cdb_value,
  input  lc3b_rob_addr          rd_tag_a,
  input  lc3b_rob_addr          rd_tag_b,
  output logic [data_width-1:0] rd_value_a,
  output logic [data_width-1:0] rd_value_b,
  output logic                  rd_done_a,
  output logic                  rd_done_b,
  input  logic                  RE,
  input  logic                  flush,
  output logic                  valid_out,
  output lc3b_opcode            opcode_out,
  output lc3b_reg               dest_out,
  output logic [data_width-1:0] value_out,
  output logic                  predict_out,
  output logic [15:0]           pc_out,
  output lc3b_rob_addr          head_addr
);

  localparam int addr_w = $bits(lc3b_rob_addr);

  rob_entry           entries [depth];
  lc3b_rob_addr       head;
  lc3b_rob_addr       tail;
  logic [addr_w:0]    count;

  logic do_alloc;
  logic do_pop;
  logic do_cdb;

  assign full       = (count == (addr_w + 1)'(depth));
  assign empty      = (count == '0);
  assign alloc_addr = tail;
  assign head_addr  = head;

  // Flush overrides everything. A full buffer never accepts dispatch, even
  // when the head pops in the same cycle. A CDB write to the entry being
  // popped is dropped so the freed slot is left clean.
  assign do_alloc = WE & ~full & ~flush;
  assign do_pop   = RE & ~empty & ~flush;
  assign do_cdb   = cdb_valid & entries[cdb_tag].busy & ~flush
                    & ~(do_pop & (cdb_tag == head));

  rob_ptr #(.width(addr_w)) u_head (
    .clk   (clk),
    .rst   (rst),
    .inc   (do_pop),
    .clr   (flush),
    .value (head)
  );

  rob_ptr #(.width(addr_w)) u_tail (
    .clk   (clk),
    .rst   (rst),
    .inc   (do_alloc),
    .clr   (flush),
    .value (tail)
  );

  // Occupancy: +1 on allocate, -1 on pop, unchanged when both happen.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (flush) begin
      count <= '0;
    end else begin
      case ({do_alloc, do_pop})
        2'b10:   count <= count + (addr_w + 1)'(1);
        2'b01:   count <= count - (addr_w + 1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry array: flush clears status bits; pop, CDB and dispatch update
  // disjoint slots (tail is never busy while dispatch is allowed).
  // NOTE: the whole array is reset, not just busy/done, because it is a
  // handful of flops and a defined payload keeps the head outputs clean.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < depth; i++) entries[i] <= '0;
    end else if (flush) begin
      for (int i = 0; i < depth; i++) begin
        entries[i].busy <= 1'b0;
        entries[i].done <= 1'b0;
      end
    end else begin
      if (do_pop) begin
        entries[head].busy <= 1'b0;
        entries[head].done <= 1'b0;
      end
      if (do_cdb) begin
        entries[cdb_tag].done  <= 1'b1;
        entries[cdb_tag].value <= cdb_value;
      end
      if (do_alloc) begin
        entries[tail] <= '{busy: 1'b1, done: 1'b0, opcode: inst_opcode,
                           dest: inst_dest, value: '0,
                           predict: inst_predict, pc: inst_pc};
      end
    end
  end

  // Head and operand read ports, with optional same-cycle CDB forwarding.
  // NOTE: every output gets a default first so no path leaves a latch.
  always_comb begin
    valid_out   = entries[head].busy & entries[head].done;
    opcode_out  = entries[head].opcode;
    dest_out    = entries[head].dest;
    value_out   = entries[head].value;
    predict_out = entries[head].predict;
    pc_out      = entries[head].pc;
    rd_done_a   = entries[rd_tag_a].busy & entries[rd_tag_a].done;
    rd_value_a  = entries[rd_tag_a].value;
    rd_done_b   = entries[rd_tag_b].busy & entries[rd_tag_b].done;
    rd_value_b  = entries[rd_tag_b].value;
`ifdef ROB_BYPASS_EN
    if (cdb_valid & entries[head].busy & (cdb_tag == head)) begin
      valid_out = 1'b1;
      value_out = cdb_value;
    end
    if (cdb_valid & entries[rd_tag_a].busy & (cdb_tag == rd_tag_a)) begin
      rd_done_a  = 1'b1;
      rd_value_a = cdb_value;
    end
    if (cdb_valid & entries[rd_tag_b].busy & (cdb_tag == rd_tag_b)) begin
      rd_done_b  = 1'b1;
      rd_value_b = cdb_value;
    end
`endif
  end

endmodule

// File: tb/tb_reorder_buffer.sv
// Self-checking bench for reorder_buffer: directed scenarios followed by a
// randomized run against a queue-based model of the buffer contents.
module tb_reorder_buffer;
  import lc3b_types::*;

  localparam int DEPTH = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         WE = 1'b0, RE = 1'b0, flush = 1'b0, cdb_valid = 1'b0;
  lc3b_opcode   inst_opcode = '0;
  lc3b_reg      inst_dest = '0;
  logic [15:0]  inst_pc = '0;
  logic         inst_predict = 1'b0;
  lc3b_rob_addr cdb_tag = '0, rd_tag_a = '0, rd_tag_b = '0;
  logic [15:0]  cdb_value = '0;
  lc3b_rob_addr alloc_addr, head_addr;
  logic         full, empty, valid_out, predict_out, rd_done_a, rd_done_b;
  logic [15:0]  rd_value_a, rd_value_b, value_out, pc_out;
  lc3b_opcode   opcode_out;
  lc3b_reg      dest_out;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  reorder_buffer #(.data_width(16), .depth(DEPTH)) dut (
    .clk(clk), .rst(rst), .WE(WE), .inst_opcode(inst_opcode),
    .inst_dest(inst_dest), .inst_pc(inst_pc), .inst_predict(inst_predict),
    .alloc_addr(alloc_addr), .full(full), .empty(empty),
    .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_value(cdb_value),
    .rd_tag_a(rd_tag_a), .rd_tag_b(rd_tag_b),
    .rd_value_a(rd_value_a), .rd_value_b(rd_value_b),
    .rd_done_a(rd_done_a), .rd_done_b(rd_done_b),
    .RE(RE), .flush(flush), .valid_out(valid_out),
    .opcode_out(opcode_out), .dest_out(dest_out), .value_out(value_out),
    .predict_out(predict_out), .pc_out(pc_out), .head_addr(head_addr)
  );

  // Reference model: the occupied entries in program order.
  typedef struct {
    int          tag;
    logic [3:0]  op;
    logic [2:0]  dest;
    logic [15:0] pc;
    logic        pred;
    bit          done;
    logic [15:0] value;
  } m_ent_t;

  m_ent_t q[$];
  int     m_head = 0;

  function automatic int m_find(input int tag);
    for (int i = 0; i < q.size(); i++) if (q[i].tag == tag) return i;
    return -1;
  endfunction

  function automatic void m_step(input bit we, input bit re, input bit fl,
                                 input bit cv, input int ct,
                                 input logic [15:0] cval);
    int  n;
    int  idx;
    bit  pop;
    m_ent_t e;
    if (fl) begin
      q.delete();
      m_head = 0;
      return;
    end
    n   = q.size();
    pop = re && (n > 0);
    idx = m_find(ct);
    if (cv && idx >= 0 && !(pop && idx == 0)) begin
      q[idx].done  = 1;
      q[idx].value = cval;
    end
    if (we && n < DEPTH) begin
      e.tag = (m_head + n) % DEPTH; e.op = inst_opcode; e.dest = inst_dest;
      e.pc = inst_pc; e.pred = inst_predict; e.done = 0; e.value = 16'h0;
      q.push_back(e);
    end
    if (pop) begin
      void'(q.pop_front());
      m_head = (m_head + 1) % DEPTH;
    end
  endfunction

  // One clock of stimulus; outputs are sampled 1 ns after the edge with
  // control inputs returned to idle.
  task automatic cycle(input bit we, input bit re, input bit fl, input bit cv,
                       input int ct, input logic [15:0] cval);
    WE = we; RE = re; flush = fl; cdb_valid = cv;
    cdb_tag = 3'(ct); cdb_value = cval;
    m_step(we, re, fl, cv, ct, cval);
    @(posedge clk);
    #1;
    WE = 0; RE = 0; flush = 0; cdb_valid = 0;
  endtask

  task automatic dispatch(input logic [3:0] op, input logic [2:0] d,
                          input logic [15:0] pc);
    inst_opcode = op; inst_dest = d; inst_pc = pc; inst_predict = 1'b0;
    cycle(1, 0, 0, 0, 0, 16'h0);
  endtask

  task automatic test_reset;
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL reset_empty got=%b exp=1", empty); end
    total++; if (full !== 1'b0) begin bad++; $display("FAIL reset_full got=%b exp=0", full); end
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b exp=0", valid_out); end
    total++; if (alloc_addr !== 3'd0) begin bad++; $display("FAIL reset_alloc got=%0d exp=0", alloc_addr); end
    total++; if (head_addr !== 3'd0) begin bad++; $display("FAIL reset_head got=%0d exp=0", head_addr); end
  endtask

  task automatic test_basic;
    total++; if (alloc_addr !== 3'd0) begin bad++; $display("FAIL basic_alloc got=%0d exp=0", alloc_addr); end
    dispatch(4'b0001, 3'd1, 16'h0010);
    total++; if (empty !== 1'b0) begin bad++; $display("FAIL basic_empty got=%b exp=0", empty); end
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL basic_valid0 got=%b exp=0", valid_out); end
    cycle(0, 0, 0, 1, 0, 16'h1234);
    total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL basic_valid1 got=%b exp=1", valid_out); end
    total++; if (value_out !== 16'h1234) begin bad++; $display("FAIL basic_value got=%h exp=1234", value_out); end
    total++; if (dest_out !== 3'd1) begin bad++; $display("FAIL basic_dest got=%0d exp=1", dest_out); end
    total++; if (pc_out !== 16'h0010) begin bad++; $display("FAIL basic_pc got=%h exp=0010", pc_out); end
    total++; if (opcode_out !== 4'b0001) begin bad++; $display("FAIL basic_opcode got=%h exp=1", opcode_out); end
    cycle(0, 1, 0, 0, 0, 16'h0);
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL basic_pop_empty got=%b exp=1", empty); end
    total++; if (head_addr !== 3'd1) begin bad++; $display("FAIL basic_pop_head got=%0d exp=1", head_addr); end
  endtask

  task automatic test_full_wrap;
    cycle(0, 0, 1, 0, 0, 16'h0);
    for (int i = 0; i < DEPTH; i++) dispatch(4'(i), 3'(i), 16'(16'h0100 + i));
    total++; if (full !== 1'b1) begin bad++; $display("FAIL wrap_full got=%b exp=1", full); end
    total++; if (alloc_addr !== 3'd0) begin bad++; $display("FAIL wrap_alloc got=%0d exp=0", alloc_addr); end
    inst_opcode = 4'hF; inst_pc = 16'hDEAD;
    cycle(1, 1, 0, 0, 0, 16'h0);
    total++; if (full !== 1'b0) begin bad++; $display("FAIL wrap_we_while_full got=%b exp=0", full); end
    total++; if (alloc_addr !== 3'd0) begin bad++; $display("FAIL wrap_tail_held got=%0d exp=0", alloc_addr); end
    total++; if (head_addr !== 3'd1) begin bad++; $display("FAIL wrap_head got=%0d exp=1", head_addr); end
    total++; if (pc_out !== 16'h0101) begin bad++; $display("FAIL wrap_head_pc got=%h exp=0101", pc_out); end
    dispatch(4'h2, 3'd2, 16'h0200);
    total++; if (full !== 1'b1) begin bad++; $display("FAIL wrap_refull got=%b exp=1", full); end
    total++; if (alloc_addr !== 3'd1) begin bad++; $display("FAIL wrap_alloc1 got=%0d exp=1", alloc_addr); end
  endtask

  task automatic test_rd_ports;
    cycle(0, 0, 1, 0, 0, 16'h0);
    for (int i = 0; i < 3; i++) dispatch(4'h1, 3'(i), 16'(i));
    cycle(0, 0, 0, 1, 2, 16'h00FF);
    rd_tag_a = 3'd2; rd_tag_b = 3'd0; #1;
    total++; if (rd_done_a !== 1'b1) begin bad++; $display("FAIL rd_done_a got=%b exp=1", rd_done_a); end
    total++; if (rd_value_a !== 16'h00FF) begin bad++; $display("FAIL rd_value_a got=%h exp=00ff", rd_value_a); end
    total++; if (rd_done_b !== 1'b0) begin bad++; $display("FAIL rd_done_b got=%b exp=0", rd_done_b); end
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL rd_head_notdone got=%b exp=0", valid_out); end
    // Pop racing a CDB write to the head: the write must be dropped.
    cycle(0, 0, 0, 1, 0, 16'h1111);
    cycle(0, 1, 0, 1, 0, 16'h2222);
    rd_tag_a = 3'd0; #1;
    total++; if (rd_value_a !== 16'h1111) begin bad++; $display("FAIL pop_beats_cdb got=%h exp=1111", rd_value_a); end
    total++; if (rd_done_a !== 1'b0) begin bad++; $display("FAIL pop_clears_done got=%b exp=0", rd_done_a); end
  endtask

  task automatic test_flush;
    inst_opcode = 4'h3;
    cycle(1, 1, 1, 1, 1, 16'h5555);
    total++; if (empty !== 1'b1) begin bad++; $display("FAIL flush_empty got=%b exp=1", empty); end
    total++; if (head_addr !== 3'd0) begin bad++; $display("FAIL flush_head got=%0d exp=0", head_addr); end
    total++; if (alloc_addr !== 3'd0) begin bad++; $display("FAIL flush_alloc got=%0d exp=0", alloc_addr); end
    for (int i = 0; i < DEPTH; i++) begin
      rd_tag_a = 3'(i); #1;
      total++; if (rd_done_a !== 1'b0) begin bad++; $display("FAIL flush_done[%0d] got=%b exp=0", i, rd_done_a); end
    end
  endtask

  task automatic test_bypass;
    cycle(0, 0, 1, 0, 0, 16'h0);
    dispatch(4'h5, 3'd4, 16'h3000);
    cdb_valid = 1'b1; cdb_tag = 3'd0; cdb_value = 16'hBEEF; rd_tag_b = 3'd0; #1;
`ifdef ROB_BYPASS_EN
    total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL byp_valid got=%b exp=1", valid_out); end
    total++; if (value_out !== 16'hBEEF) begin bad++; $display("FAIL byp_value got=%h exp=beef", value_out); end
    total++; if (rd_done_b !== 1'b1) begin bad++; $display("FAIL byp_rd_done got=%b exp=1", rd_done_b); end
`else
    total++; if (valid_out !== 1'b0) begin bad++; $display("FAIL nobyp_valid got=%b exp=0", valid_out); end
    total++; if (rd_done_b !== 1'b0) begin bad++; $display("FAIL nobyp_rd_done got=%b exp=0", rd_done_b); end
`endif
    cycle(0, 0, 0, 1, 0, 16'hBEEF);
    total++; if (valid_out !== 1'b1) begin bad++; $display("FAIL byp_next_valid got=%b exp=1", valid_out); end
    total++; if (value_out !== 16'hBEEF) begin bad++; $display("FAIL byp_next_value got=%h exp=beef", value_out); end
  endtask

  task automatic test_random;
    int ct, idx, t;
    bit exp_done;
    cycle(0, 0, 1, 0, 0, 16'h0);
    for (int n = 0; n < 400; n++) begin
      inst_opcode  = 4'($urandom);
      inst_dest    = 3'($urandom);
      inst_pc      = 16'($urandom);
      inst_predict = 1'($urandom);
      if (q.size() > 0 && $urandom_range(0, 3) != 0)
        ct = q[$urandom_range(0, q.size() - 1)].tag;
      else
        ct = $urandom_range(0, DEPTH - 1);
      cycle($urandom_range(0, 99) < 55, $urandom_range(0, 99) < 40,
            $urandom_range(0, 99) < 3, $urandom_range(0, 99) < 50,
            ct, 16'($urandom));
      total++; if (empty !== (q.size() == 0)) begin bad++; $display("FAIL rnd_empty n=%0d got=%b", n, empty); end
      total++; if (full !== (q.size() == DEPTH)) begin bad++; $display("FAIL rnd_full n=%0d got=%b", n, full); end
      total++; if (alloc_addr !== 3'((m_head + q.size()) % DEPTH)) begin
        bad++; $display("FAIL rnd_alloc n=%0d got=%0d exp=%0d", n, alloc_addr, (m_head + q.size()) % DEPTH); end
      total++; if (head_addr !== 3'(m_head)) begin
        bad++; $display("FAIL rnd_head n=%0d got=%0d exp=%0d", n, head_addr, m_head); end
      exp_done = (q.size() > 0) && q[0].done;
      total++; if (valid_out !== exp_done) begin
        bad++; $display("FAIL rnd_valid n=%0d got=%b exp=%b", n, valid_out, exp_done); end
      if (q.size() > 0) begin
        total++;
        if (opcode_out !== q[0].op || dest_out !== q[0].dest || pc_out !== q[0].pc || predict_out !== q[0].pred) begin
          bad++; $display("FAIL rnd_head_fields n=%0d got=%h/%h/%h/%b exp=%h/%h/%h/%b", n,
                          opcode_out, dest_out, pc_out, predict_out, q[0].op, q[0].dest, q[0].pc, q[0].pred);
        end
        if (exp_done) begin
          total++; if (value_out !== q[0].value) begin
            bad++; $display("FAIL rnd_head_value n=%0d got=%h exp=%h", n, value_out, q[0].value); end
        end
      end
      t = $urandom_range(0, DEPTH - 1);
      rd_tag_a = 3'(t); #1;
      idx = m_find(t);
      exp_done = (idx >= 0) && q[idx].done;
      total++; if (rd_done_a !== exp_done) begin
        bad++; $display("FAIL rnd_rd_done n=%0d tag=%0d got=%b exp=%b", n, t, rd_done_a, exp_done); end
      if (exp_done) begin
        total++; if (rd_value_a !== q[idx].value) begin
          bad++; $display("FAIL rnd_rd_value n=%0d tag=%0d got=%h exp=%h", n, t, rd_value_a, q[idx].value); end
      end
    end
  endtask

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    test_reset();
    test_basic();
    test_full_wrap();
    test_rd_ports();
    test_flush();
    q.delete(); m_head = 0;
    test_bypass();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
Circular reorder buffer that feeds in-order commit.
- Dispatch allocates entries at the tail.
- The common data bus (CDB) marks entries done and writes their result value.
- The commit controller reads the head entry and pops it with RE.
- The commit controller's flush empties the whole buffer.
- Two tag-indexed read ports serve reservation-station operand fetch.

Parameters:
data_width, 16, width of result value field
depth, 8, number of entries; power of two; must equal 2**$bits(lc3b_rob_addr)

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-high reset
WE  in  1  dispatch allocate request
inst_opcode  in  lc3b_opcode  opcode of dispatched instruction
inst_dest  in  lc3b_reg  destination register (branch: nzp in same field)
inst_pc  in  16  PC of dispatched instruction
inst_predict  in  1  branch prediction taken bit
alloc_addr  out  lc3b_rob_addr  tag assigned to dispatch (current tail)
full  out  1  no free entry
empty  out  1  no occupied entry
cdb_valid  in  1  result broadcast valid
cdb_tag  in  lc3b_rob_addr  entry the result belongs to
cdb_value  in  data_width  result value
rd_tag_a, rd_tag_b  in  lc3b_rob_addr  operand lookup tags
rd_value_a, rd_value_b  out  data_width  stored value of looked-up entry
rd_done_a, rd_done_b  out  1  looked-up entry busy and done
RE  in  1  commit pop from commit controller
flush  in  1  discard all entries
valid_out  out  1  head entry busy and done
opcode_out  out  lc3b_opcode  head opcode
dest_out  out  lc3b_reg  head dest/nzp
value_out  out  data_width  head value
predict_out  out  1  head predict bit
pc_out  out  16  head PC
head_addr  out  lc3b_rob_addr  tag of head entry

Behaviour:
- Entry state: busy, done, opcode, dest, value, predict, pc.
- Pointers: head, tail (log2(depth) bits, wrap modulo depth), count (log2(depth)+1 bits).
- Reset (async): head=tail=count=0; all busy=0, done=0.
- Outputs after reset: full=0, empty=1, valid_out=0, alloc_addr=0, head_addr=0; data outputs reflect entry 0 (don't-care).
- full = (count==depth); empty = (count==0); alloc_addr = tail; head_addr = head.
- valid_out = busy[head] & done[head]. All head outputs are combinational from state.
- Dispatch, when WE & ~full at posedge:
  - entry[tail] gets busy=1, done=0, value=0 and the inst_* fields.
  - tail increments.
  - WE while full is ignored, even if RE pops in the same cycle (full is not bypassed).
- CDB, when cdb_valid & busy[cdb_tag]:
  - done=1 and value=cdb_value at posedge.
  - CDB to a non-busy entry is ignored.
  - Result is visible on valid_out/rd_* the next cycle.
- Commit, when RE & ~empty:
  - busy[head]=0, done[head]=0, head increments.
  - RE while empty is ignored. RE is honoured even if valid_out=0; that is the commit controller's responsibility.
- Simultaneous events:
  - WE and RE in the same cycle: count unchanged, both pointers advance.
  - CDB and RE to the same head entry: the pop wins and the CDB write is dropped.
- Flush (synchronous, highest priority): head=tail=count=0 and all busy/done cleared. WE, RE and CDB in that cycle are ignored.
- Read ports are combinational: rd_done_x = busy & done at rd_tag_x; rd_value_x = value at rd_tag_x.
- No internal stall cycles. Single-cycle state update for all operations.

Optional Feature:
ROB_BYPASS_EN.
- Defined: CDB write forwards combinationally to the head and read ports.
  - If cdb_valid & busy[head] & cdb_tag==head: valid_out=1 and value_out=cdb_value in the same cycle.
  - Read ports likewise assert rd_done_x and forward cdb_value on a tag match.
- Undefined: no forwarding. A result becomes visible one cycle after the CDB write.

Decomposition:
- lc3b_types: lc3b_rob_addr, lc3b_opcode, lc3b_reg, lc3b_word already exist. Add a packed rob_entry struct {busy, done, opcode, dest, value, predict, pc}.
- Sub-module rob_ptr: modulo-depth pointer with inc and clr, async rst. Instantiated for head and tail.
- The entry array stays inside reorder_buffer.

Test Plan:
- Reset, then dispatch ADD (dest R1, pc x0010) -> alloc_addr=0; next cycle empty=0, valid_out=0.
- CDB tag 0, value x1234 -> next cycle valid_out=1, value_out=x1234, dest_out=R1, pc_out=x0010; RE -> next cycle empty=1.
- Dispatch 8 entries -> full=1; 9th WE with RE same cycle -> tail unchanged, count 7, then 8 on next dispatch; pointers wrap to 0 correctly.
- Entries 0..2 busy, CDB tag 2 value x00FF -> rd_tag_a=2 gives rd_done_a=1, rd_value_a=x00FF; valid_out stays 0 until head 0 is done.
- Flush with WE, CDB and RE all asserted in the same cycle -> next cycle empty=1, head_addr=0, alloc_addr=0, no entry busy.
- ROB_BYPASS_EN defined: CDB tag==head value xBEEF -> valid_out=1, value_out=xBEEF in the same cycle. Undefined -> valid_out=1 only in the next cycle.
